// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the fpadd normalization stage: datapath widths,
// rounding-mode encodings and the rounder sideband bundle.
package fp_norm_pkg;

    localparam int W     = 64;
    localparam int SHW   = 6;
    localparam int EXP_W = 11;

    // Any rm with bit 2 set selects round-to-nearest-away; RNA is its canonical form.
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RZ  = 3'b001,
        RU  = 3'b010,
        RD  = 3'b011,
        RNA = 3'b100
    } rm_e;

    typedef struct packed {
        logic       Asign;
        logic [2:0] rm;
        logic [1:0] P;
        logic       OvEn;
        logic       UnEn;
        logic [3:0] sel_inv;
        logic       Invalid;
        logic       DenormIn;
        logic       convert;
    } side_t;

    localparam int SIDE_W = $bits(side_t);

    function automatic logic is_rna(input logic [2:0] rm);
        return rm[2];
    endfunction

endpackage

// File: rtl/lzc64.sv
// Combinational 64-bit leading-zero counter built from a tree of 2-bit
// count/valid merges; the count is forced to 0 for an all-zero input.
module lzc64 (
    input  logic [63:0] data_i,
    output logic [5:0]  count_o,
    output logic        zero_o
);

    // Returns {any_one, count}. Level l merges pairs of l-bit counts into (l+1)-bit
    // counts in place: the upper half wins when it holds a one, otherwise the lower
    // half's count gets the 2^l offset for the zeros above it.
    function automatic logic [6:0] lzc_tree(input logic [63:0] d);
        logic [5:0] cnt [32];
        logic       vld [32];
        for (int i = 0; i < 32; i++) begin
            vld[i] = d[2*i+1] | d[2*i];
            cnt[i] = {5'd0, ~d[2*i+1]};
        end
        for (int l = 1; l < 6; l++) begin
            for (int i = 0; i < (32 >> l); i++) begin
                if (vld[2*i+1])
                    cnt[i] = cnt[2*i+1];
                else
                    cnt[i] = cnt[2*i] | (6'd1 << l);
                vld[i] = vld[2*i+1] | vld[2*i];
            end
        end
        return {vld[0], cnt[0]};
    endfunction

    logic [6:0] tree;

    assign tree    = lzc_tree(data_i);
    assign zero_o  = ~tree[6];
    assign count_o = tree[6] ? tree[5:0] : 6'd0;

endmodule

// File: rtl/fp_norm_stage.sv
// Two-stage normalization pipeline between the significand adder and the rounder:
// S1 captures the sum with its leading-zero count, S2 left-justifies it to bit 63.
module fp_norm_stage
    import fp_norm_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_sum,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      A,
    output logic [EXP_W-1:0]  Aexp,
    output logic [SHW-1:0]    norm_shift,
    output logic              exp_valid,
    output logic [SIDE_W-1:0] out_side
);

    logic [SHW-1:0]    lz;
    logic              lz_zero;

    logic              s1_valid_q, s1_valid_d;
    logic [W-1:0]      s1_sum_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [SIDE_W-1:0] s1_side_q;
    logic [SHW-1:0]    s1_lz_q;
    logic              s1_z_q;

    logic              s2_valid_q, s2_valid_d;
    logic [W-1:0]      a_q;
    logic [EXP_W-1:0]  aexp_q;
    logic [SHW-1:0]    shift_q;
    logic              expv_q;
    logic [SIDE_W-1:0] side_q;

    logic              s2_take, s1_take, s1_load, s2_load;

    lzc64 u_lzc (
        .data_i  (in_sum),
        .count_o (lz),
        .zero_o  (lz_zero)
    );

    // A stage may take new data when it is empty or its contents leave this cycle,
    // so in_ready ripples combinationally back from out_ready.
    assign s2_take  = out_ready | ~s2_valid_q;
    assign s1_take  = s2_take | ~s1_valid_q;
    assign in_ready = s1_take;
    assign s1_load  = in_valid & s1_take;
    assign s2_load  = s1_valid_q & s2_take;

    always_comb begin
        s1_valid_d = s1_take ? in_valid : s1_valid_q;
        s2_valid_d = s2_take ? s1_valid_q : s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    // NOTE: data registers are reset as well because the rounder sees all-zero
    // outputs while the pipeline is held in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_exp_q   <= '0;
            s1_side_q  <= '0;
            s1_lz_q    <= '0;
            s1_z_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_sum_q  <= in_sum;
                s1_exp_q  <= in_exp;
                s1_side_q <= in_side;
                s1_lz_q   <= lz;
                s1_z_q    <= lz_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            aexp_q     <= '0;
            shift_q    <= '0;
            expv_q     <= 1'b0;
            side_q     <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                a_q     <= s1_sum_q << s1_lz_q;
                aexp_q  <= s1_exp_q;
                shift_q <= s1_lz_q;
                expv_q  <= ~s1_z_q;
                side_q  <= s1_side_q;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign A          = a_q;
    assign Aexp       = aexp_q;
    assign norm_shift = shift_q;
    assign exp_valid  = expv_q;
    assign out_side   = side_q;

endmodule

// File: tb/tb_fp_norm_stage.sv
// Directed testbench for fp_norm_stage: carry, cancellation, zero, back-pressure,
// flush and asynchronous reset scenarios with hand-computed expectations.
module tb_fp_norm_stage;
    import fp_norm_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_sum;
    logic [10:0]       in_exp;
    side_t             in_side;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       A;
    logic [10:0]       Aexp;
    logic [5:0]        norm_shift;
    logic              exp_valid;
    logic [SIDE_W-1:0] out_side;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_norm_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_exp     (in_exp),
        .in_side    (in_side),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A          (A),
        .Aexp       (Aexp),
        .norm_shift (norm_shift),
        .exp_valid  (exp_valid),
        .out_side   (out_side)
    );

    function automatic side_t mk_side(input logic asign, input logic [2:0] rm,
                                      input logic [3:0] sel);
        side_t s;
        s          = '0;
        s.Asign    = asign;
        s.rm       = rm;
        s.P        = 2'b10;
        s.OvEn     = 1'b1;
        s.UnEn     = 1'b0;
        s.sel_inv  = sel;
        s.Invalid  = 1'b0;
        s.DenormIn = sel[0];
        s.convert  = sel[1];
        return s;
    endfunction

    // Every task starts and ends at posedge+1 so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand into an empty pipeline with out_ready=1 and returns the
    // cycles until out_valid (bounded); outputs are left visible for the caller.
    task automatic send_and_get(input logic [63:0] sum, input logic [10:0] exp,
                                input side_t side, output logic acc, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = sum;
        in_exp    = exp;
        in_side   = side;
        #1;
        acc = in_ready;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_exp    = '0;
        in_side   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, A, Aexp, norm_shift, exp_valid, out_side} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b A=%h Aexp=%h shift=%0d ev=%0b side=%h required all zero",
                     out_valid, A, Aexp, norm_shift, exp_valid, out_side);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry();
        logic acc;
        int   lat;
        send_and_get(64'h8000_0000_0000_0001, 11'h400, mk_side(1'b0, RNE, 4'h3), acc, lat);
        checks++;
        if (acc !== 1'b1 || lat != 2) begin
            failures++;
            $display("FAIL carry_latency: got accept=%0b latency=%0d required 1/2", acc, lat);
        end
        checks++;
        if (A !== 64'h8000_0000_0000_0001 || norm_shift !== 6'd0 || exp_valid !== 1'b1 || Aexp !== 11'h400) begin
            failures++;
            $display("FAIL carry_data: got A=%h shift=%0d ev=%0b Aexp=%h required 8000000000000001/0/1/400",
                     A, norm_shift, exp_valid, Aexp);
        end
        step();
    endtask

    task automatic test_cancellation();
        logic acc;
        int   lat;
        send_and_get(64'h0000_0000_0000_0A00, 11'h3FF, mk_side(1'b0, RZ, 4'h9), acc, lat);
        checks++;
        if (lat != 2 || A !== 64'hA000_0000_0000_0000 || norm_shift !== 6'd52 || exp_valid !== 1'b1
            || Aexp !== 11'h3FF || out_side !== mk_side(1'b0, RZ, 4'h9)) begin
            failures++;
            $display("FAIL cancel_data: got lat=%0d A=%h shift=%0d ev=%0b Aexp=%h side=%h required 2/a000000000000000/52/1/3ff/%h",
                     lat, A, norm_shift, exp_valid, Aexp, out_side, mk_side(1'b0, RZ, 4'h9));
        end
        step();
        send_and_get(64'h4000_0000_0000_0000, 11'h010, mk_side(1'b0, RU, 4'h1), acc, lat);
        checks++;
        if (A !== 64'h8000_0000_0000_0000 || norm_shift !== 6'd1 || exp_valid !== 1'b1) begin
            failures++;
            $display("FAIL normal_case: got A=%h shift=%0d ev=%0b required 8000000000000000/1/1",
                     A, norm_shift, exp_valid);
        end
        step();
        send_and_get(64'h0000_0000_0000_0001, 11'h001, mk_side(1'b0, RU, 4'h2), acc, lat);
        checks++;
        if (A !== 64'h8000_0000_0000_0000 || norm_shift !== 6'd63 || exp_valid !== 1'b1 || Aexp !== 11'h001) begin
            failures++;
            $display("FAIL max_shift: got A=%h shift=%0d ev=%0b Aexp=%h required 8000000000000000/63/1/001",
                     A, norm_shift, exp_valid, Aexp);
        end
        step();
    endtask

    task automatic test_zero();
        logic  acc;
        int    lat;
        side_t s;
        s = mk_side(1'b1, RD, 4'h5);
        send_and_get(64'h0, 11'h2AB, s, acc, lat);
        checks++;
        if (lat != 2 || A !== 64'h0 || norm_shift !== 6'd0 || exp_valid !== 1'b0 || Aexp !== 11'h2AB) begin
            failures++;
            $display("FAIL zero_data: got lat=%0d A=%h shift=%0d ev=%0b Aexp=%h required 2/0/0/0/2ab",
                     lat, A, norm_shift, exp_valid, Aexp);
        end
        checks++;
        if (out_side !== s || out_side[13:11] !== 3'b011 || out_side[14] !== 1'b1) begin
            failures++;
            $display("FAIL zero_side: got %h required %h", out_side, s);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] sums   [4] = '{64'h0000_0001_0000_0000, 64'h4000_0000_0000_0003,
                                    64'h0000_0000_0000_0001, 64'h00F0_0000_0000_0000};
        logic [63:0] a_exp  [4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0006,
                                    64'h8000_0000_0000_0000, 64'hF000_0000_0000_0000};
        logic [5:0]  sh_exp [4] = '{6'd31, 6'd1, 6'd63, 6'd8};
        int n_in        = 0;
        int n_out       = 0;
        int first_block = -1;
        for (int c = 0; c < 40 && n_out < 4; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = (n_in < 4);
            if (n_in < 4) begin
                in_sum  = sums[n_in];
                in_exp  = 11'h101 + 11'(n_in);
                in_side = mk_side(n_in[0], RNE, 4'(n_in + 8));
            end
            @(negedge clk);
            if (!in_ready && first_block < 0) first_block = n_in;
            if (c >= 2 && c <= 6) begin
                checks++;
                if (out_valid !== 1'b1 || A !== a_exp[0] || norm_shift !== sh_exp[0] || Aexp !== 11'h101) begin
                    failures++;
                    $display("FAIL stall_hold: cycle %0d got valid=%0b A=%h shift=%0d Aexp=%h required 1/%h/%0d/101",
                             c, out_valid, A, norm_shift, Aexp, a_exp[0], sh_exp[0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (A !== a_exp[n_out] || norm_shift !== sh_exp[n_out] || exp_valid !== 1'b1
                    || Aexp !== 11'h101 + 11'(n_out) || out_side !== mk_side(n_out[0], RNE, 4'(n_out + 8))) begin
                    failures++;
                    $display("FAIL b2b_out%0d: got A=%h shift=%0d Aexp=%h side=%h required A=%h shift=%0d Aexp=%h",
                             n_out, A, norm_shift, Aexp, out_side, a_exp[n_out], sh_exp[n_out], 11'h101 + 11'(n_out));
                end
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (first_block != 2) begin
            failures++;
            $display("FAIL b2b_ready_drop: got accepts_before_block=%0d required 2", first_block);
        end
        checks++;
        if (n_out != 4 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: got outputs=%0d trailing_valid=%0b required 4/0", n_out, out_valid);
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        logic rdy;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 64'h0000_0000_FFFF_0000;
        in_exp    = 11'h011;
        in_side   = mk_side(1'b0, RNE, 4'hA);
        step();
        in_sum = 64'h0000_1000_0000_0000;
        in_exp = 11'h022;
        step();
        in_sum = 64'h2000_0000_0000_0000;
        in_exp = 11'h033;
        flush  = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_valid: got out_valid=%0b required 0", out_valid);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_leak: got output_seen=%0b required 0", seen);
        end
        // Flush into an empty pipeline while in_ready is high: the operand must vanish.
        in_valid = 1'b1;
        in_sum   = 64'h0000_0000_0000_00FF;
        flush    = 1'b1;
        #1;
        rdy = in_ready;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (rdy !== 1'b1 || seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready_drop: got in_ready=%0b output_seen=%0b required 1/0", rdy, seen);
        end
    endtask

    task automatic test_async_reset();
        logic acc;
        int   lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 64'h0000_0000_0000_0100;
        in_exp    = 11'h055;
        in_side   = mk_side(1'b1, RU, 4'hF);
        step();
        in_sum = 64'h0000_0000_0800_0000;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || norm_shift !== 6'd55) begin
            failures++;
            $display("FAIL pre_reset_full: got valid=%0b shift=%0d required 1/55", out_valid, norm_shift);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, A, Aexp, norm_shift, exp_valid, out_side} !== '0) begin
            failures++;
            $display("FAIL async_reset: got valid=%0b A=%h Aexp=%h shift=%0d ev=%0b side=%h required all zero",
                     out_valid, A, Aexp, norm_shift, exp_valid, out_side);
        end
        #2;
        reset_n = 1'b1;
        step();
        send_and_get(64'h4000_0000_0000_0000, 11'h3FE, mk_side(1'b0, RNE, 4'h0), acc, lat);
        checks++;
        if (acc !== 1'b1 || lat != 2 || norm_shift !== 6'd1 || A !== 64'h8000_0000_0000_0000 || Aexp !== 11'h3FE) begin
            failures++;
            $display("FAIL post_reset_op: got acc=%0b lat=%0d shift=%0d A=%h Aexp=%h required 1/2/1/8000000000000000/3fe",
                     acc, lat, norm_shift, A, Aexp);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_stale: got out_valid=%0b required 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_cancellation();
        test_zero();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_norm_stage.md
Name: fp_norm_stage

Overview:
- Pipelined normalization stage of the fpadd datapath. Sits between the significand adder and the combinational rounder.
- Takes the raw 64-bit adder magnitude and the pre-normalization exponent, counts leading zeros, and left-shifts so the leading one lands at bit 63.
- Emits A, Aexp, norm_shift and exp_valid exactly as the rounder consumes them.
- Forwards all rounder control sideband in lockstep, with valid/ready flow control and a synchronous flush.

Parameters:
- W, 64, magnitude width (fixed to 64 for the fpadd datapath; other values unsupported).
- SHW, 6, shift-count width (clog2(W)).

Ports:
- clk  in  1  clock, all flops rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; clears both pipeline stages.
- in_valid  in  1  upstream has a valid operand.
- in_ready  out  1  stage can accept this cycle.
- in_sum  in  64  adder magnitude. Bit 63 = carry position, bit 62 = integer bit of aligned operand, bit 0 already holds alignment sticky.
- in_exp  in  11  pre-normalization exponent (larger operand's exponent).
- in_side  in  SIDE_W  sideband bundle (fp_norm_pkg::side_t): Asign, rm[2:0], P[1:0], OvEn, UnEn, sel_inv[3:0], Invalid, DenormIn, convert.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  rounder/writeback accepts.
- A  out  64  normalized magnitude; A[63]=1 whenever exp_valid=1.
- Aexp  out  11  in_exp passed through unchanged.
- norm_shift  out  6  left-shift amount applied (leading-zero count).
- exp_valid  out  1  0 iff in_sum was all zeros.
- out_side  out  SIDE_W  sideband, aligned with A.

Behaviour:
- Two register stages, latency 2 cycles from accepted input to out_valid with no back-pressure; throughput 1 per cycle.
- S1 (capture): registers in_sum, in_exp, in_side, plus the LZC result lz[5:0] and zero flag z = (in_sum==0), computed combinationally from in_sum.
- S2 (shift): registers A = s1_sum << s1_lz (zeros fill from bit 0), norm_shift = s1_lz, exp_valid = ~s1_z, Aexp, side.
- Zero sum: lz forced to 0, A=0, norm_shift=0, exp_valid=0.
- Exponent is never modified here. Rounder computes Aexp - norm_shift + 1 + Cout:
  - carry case (in_sum[63]=1): shift 0, exponent +1.
  - normal case (in_sum[62]=1): shift 1, exponent unchanged.
- No denormal clamp. Shift may exceed the exponent; the rounder's underflow path handles that.
- Handshake, per stage k: advance_k = valid_k & (downstream stage empty or taking).
  - s2_take = out_ready | ~s2_valid.
  - s1_take = s2_take | ~s1_valid.
  - in_ready = s1_take (combinational from out_ready; no register between them).
- Transfer on in_valid & in_ready. out_valid = s2_valid.
- While out_valid & ~out_ready: A, Aexp, norm_shift, exp_valid, out_side are held stable.
- Data registers load only on stage advance. Valid bits update every cycle.
- flush=1: s1_valid and s2_valid go 0 at the next edge. An input presented the same cycle is discarded even if in_ready=1. Data registers are don't-care.
- Reset (reset_n low, async): s1_valid=s2_valid=0 so out_valid=0. A=0, Aexp=0, norm_shift=0, exp_valid=0, out_side=0. in_ready=1 once reset is released.
- Reset mid-operation: all in-flight entries are lost; no partial output.
- Simultaneous S2 drain and S1 refill in one cycle is legal: the full pipeline stays full at one transfer per cycle.

Decomposition:
- fp_norm_pkg holds:
  - side_t packed struct (field order as listed in Ports) and SIDE_W.
  - constants W=64, SHW=6.
  - rm encodings RNE=3'b000, RZ=3'b001, RU=3'b010, RD=3'b011, RNA=3'b1xx.
- One sub-module, lzc64: combinational leading-zero counter, 64-bit input, outputs count[5:0] and zero flag. Implemented as a tree of 2-bit count/valid merges.
- Shifter is inline in fp_norm_stage.

Test Plan:
- Carry case: in_sum=64'h8000_0000_0000_0001, in_exp=11'h400, out_ready=1 -> 2 cycles later A=64'h8000_0000_0000_0001, norm_shift=0, exp_valid=1, Aexp=11'h400.
- Cancellation: in_sum=64'h0000_0000_0000_0A00, in_exp=11'h3FF -> norm_shift=52, A=64'hA000_0000_0000_0000, exp_valid=1.
- Zero result: in_sum=0, in_side.rm=RD, Asign=1 -> A=0, norm_shift=0, exp_valid=0, out_side forwarded intact (rm=3'b011, Asign=1).
- Back-pressure: 4 back-to-back inputs, out_ready=0 from cycle 2 to cycle 6:
  - in_ready drops after 2 accepts.
  - outputs stay stable while stalled.
  - all 4 emerge in order, none lost or duplicated, once out_ready=1.
- Flush: pipeline full, flush=1 together with in_valid=1 -> next cycle out_valid=0, and no output ever appears for any of the 3 operands.
- Async reset: assert reset_n=0 mid-stream between clock edges -> out_valid and all outputs go 0 immediately. After release, a new operand in_sum=64'h4000_0000_0000_0000 yields norm_shift=1, A=64'h8000_0000_0000_0000.
